// File: rtl/mandel_scan_ctrl.sv
// Mandelbrot scan controller: walks the frame in raster order, handing out per-pixel complex coordinates.
// Define SCAN_CENTER_TRACK_EN to take the view centre from center_x/center_y; otherwise it is fixed at (-0.5, 0).
module mandel_scan_ctrl #(
    parameter int FP_WIDTH   = 26,
    parameter int FP_INT     = 6,
    parameter int H_RES      = 800,
    parameter int V_RES      = 600,
    parameter int ADDR_WIDTH = 19,
    parameter int STEP0      = 5243,
    parameter int ZOOM_MAX   = 15
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       zoom_in,
    input  logic                       zoom_out,
    input  logic signed [FP_WIDTH-1:0] center_x,
    input  logic signed [FP_WIDTH-1:0] center_y,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic signed [FP_WIDTH-1:0] c_re,
    output logic signed [FP_WIDTH-1:0] c_im,
    output logic [ADDR_WIDTH-1:0]      addr,
    output logic                       frame_done,
    output logic [3:0]                 zoom_level
);

    localparam int FRAC  = FP_WIDTH - FP_INT;
    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(H_RES - 1);
    localparam logic [FP_WIDTH-1:0]   HALF_H    = FP_WIDTH'(H_RES / 2);
    localparam logic [FP_WIDTH-1:0]   HALF_V    = FP_WIDTH'(V_RES / 2);
    localparam logic [FP_WIDTH-1:0]   STEP0_W   = FP_WIDTH'(STEP0);
    localparam logic [3:0]            ZMAX      = 4'(ZOOM_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [FP_WIDTH-1:0]   c_re_q, c_re_d;
    logic [FP_WIDTH-1:0]   c_im_q, c_im_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  frame_done_q, frame_done_d;
    logic [3:0]            zoom_level_q, zoom_level_d;
    logic [3:0]            pend_q, pend_d;
    logic                  zin_q, zin_d;
    logic                  zout_q, zout_d;
    logic [FP_WIDTH-1:0]   step_q, step_d;
    logic [FP_WIDTH-1:0]   re0_q, re0_d;

    logic [FP_WIDTH-1:0]   cx, cy;
    logic [FP_WIDTH-1:0]   step_load, re0_calc, im0_calc;
    logic                  rise_in, rise_out, fire;

`ifdef SCAN_CENTER_TRACK_EN
    assign cx = center_x;
    assign cy = center_y;
`else
    localparam logic [FP_WIDTH-1:0] HALF_FP = FP_WIDTH'(1) << (FRAC - 1);
    localparam logic [FP_WIDTH-1:0] CX_FIX  = -HALF_FP;

    logic unused_center;
    assign unused_center = ^{center_x, center_y};
    assign cx = CX_FIX;
    assign cy = '0;
`endif

    assign step_load = STEP0_W >> pend_q;
    assign re0_calc  = cx - step_load * HALF_H;
    assign im0_calc  = cy + step_load * HALF_V;
    assign rise_in   = zoom_in & ~zin_q;
    assign rise_out  = zoom_out & ~zout_q;
    assign fire      = out_valid_q & out_ready;

    // NOTE: every _d starts from its _q (or a pulse default) so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        c_re_d       = c_re_q;
        c_im_d       = c_im_q;
        addr_d       = addr_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        zoom_level_d = zoom_level_q;
        step_d       = step_q;
        re0_d        = re0_q;
        zin_d        = zoom_in;
        zout_d       = zoom_out;
        pend_d       = pend_q;

        // Opposing edges in the same cycle cancel; the pending level is only consumed by LOAD.
        if (rise_in && !rise_out && pend_q < ZMAX) begin
            pend_d = pend_q + 4'd1;
        end else if (rise_out && !rise_in && pend_q != 4'd0) begin
            pend_d = pend_q - 4'd1;
        end

        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                zoom_level_d = pend_q;
                step_d       = step_load;
                re0_d        = re0_calc;
                c_re_d       = re0_calc;
                c_im_d       = im0_calc;
                addr_d       = '0;
                col_d        = '0;
                out_valid_d  = 1'b1;
                state_d      = SCAN;
            end
            SCAN: begin
                if (fire) begin
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
                    if (col_q == LAST_COL) begin
                        col_d  = '0;
                        c_re_d = re0_q;
                        c_im_d = c_im_q - step_q;
                    end else begin
                        col_d  = col_q + COL_W'(1);
                        c_re_d = c_re_q + step_q;
                    end
                    if (addr_q == LAST_ADDR) begin
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            c_re_q       <= '0;
            c_im_q       <= '0;
            addr_q       <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            zoom_level_q <= '0;
            pend_q       <= '0;
            zin_q        <= 1'b0;
            zout_q       <= 1'b0;
            step_q       <= '0;
            re0_q        <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            c_re_q       <= c_re_d;
            c_im_q       <= c_im_d;
            addr_q       <= addr_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            zoom_level_q <= zoom_level_d;
            pend_q       <= pend_d;
            zin_q        <= zin_d;
            zout_q       <= zout_d;
            step_q       <= step_d;
            re0_q        <= re0_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign c_re       = c_re_q;
    assign c_im       = c_im_q;
    assign addr       = addr_q;
    assign frame_done = frame_done_q;
    assign zoom_level = zoom_level_q;

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Scoreboard bench for mandel_scan_ctrl on a 4x3 frame; expected jobs are queued by the stimulus
// and consumed by a negedge monitor whenever a job is presented.
module tb_mandel_scan_ctrl;

    localparam int FPW = 26;
    localparam int AW  = 19;

`ifdef SCAN_CENTER_TRACK_EN
    localparam int CX_A = 0;
    localparam int CY_A = 0;
    localparam int CX_B = 100000;
    localparam int CY_B = -200000;
`else
    localparam int CX_A = -524288;
    localparam int CY_A = 0;
    localparam int CX_B = -524288;
    localparam int CY_B = 0;
`endif

    typedef struct {
        logic signed [FPW-1:0] re;
        logic signed [FPW-1:0] im;
        logic [AW-1:0]         addr;
        logic [3:0]            zoom;
    } job_t;

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic                  zoom_in, zoom_out, out_ready;
    logic signed [FPW-1:0] center_x, center_y;
    logic                  out_valid, frame_done;
    logic signed [FPW-1:0] c_re, c_im;
    logic [AW-1:0]         addr;
    logic [3:0]            zoom_level;

    int   checks = 0;
    int   errors = 0;
    job_t sb[$];
    job_t exp_job;
    logic exp_done = 1'b0;
    logic done_next;

    mandel_scan_ctrl #(.H_RES(4), .V_RES(3)) dut (
        .CLK(CLK), .RESET(RESET), .zoom_in(zoom_in), .zoom_out(zoom_out),
        .center_x(center_x), .center_y(center_y), .out_ready(out_ready),
        .out_valid(out_valid), .c_re(c_re), .c_im(c_im), .addr(addr),
        .frame_done(frame_done), .zoom_level(zoom_level)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hand-computed pixel pitch for the zoom levels this bench visits: 5243>>z.
    function automatic int step_of(input int z);
        case (z)
            0:       return 5243;
            3:       return 655;
            4:       return 327;
            default: return 0;
        endcase
    endfunction

    task automatic push_frame(input int z, input int cx, input int cy);
        job_t j;
        int   s;
        s = step_of(z);
        for (int r = 0; r < 3; r++) begin
            for (int col = 0; col < 4; col++) begin
                j.re   = FPW'(cx + (col - 2) * s);
                j.im   = FPW'(cy + (1 - r) * s);
                j.addr = AW'(r * 4 + col);
                j.zoom = 4'(z);
                sb.push_back(j);
            end
        end
    endtask

    task automatic wait_job(input int a);
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK); #1;
            if (out_valid && addr == AW'(a)) return;
        end
        checks++; errors++;
        $display("FAIL wait_job: addr %0d never presented within 200 cycles", a);
    endtask

    task automatic wait_frame_done();
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK); #1;
            if (frame_done) return;
        end
        checks++; errors++;
        $display("FAIL wait_frame_done: no frame_done within 200 cycles");
    endtask

    task automatic pulse(input logic zi, input logic zo);
        zoom_in = zi; zoom_out = zo;
        @(posedge CLK); #1;
        zoom_in = 1'b0; zoom_out = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_c_re"}, c_re, 0);
        check({tag, "_c_im"}, c_im, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_zoom_level"}, zoom_level, 0);
    endtask

    // Monitor: compares every presented job against the queue head; pops on handshake.
    always @(negedge CLK) begin
        if (RESET) begin
            exp_done = 1'b0;
        end else begin
            check("frame_done", frame_done, exp_done);
            done_next = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_job: addr %0d presented, expected none", addr);
                end else begin
                    exp_job = sb[0];
                    check("c_re", c_re, exp_job.re);
                    check("c_im", c_im, exp_job.im);
                    check("addr", addr, exp_job.addr);
                    check("zoom_level", zoom_level, exp_job.zoom);
                    if (out_ready) begin
                        done_next = (exp_job.addr == AW'(11));
                        void'(sb.pop_front());
                    end
                end
            end
            exp_done = done_next;
        end
    end

    initial begin
        RESET = 1'b1; zoom_in = 1'b0; zoom_out = 1'b0; out_ready = 1'b1;
        center_x = FPW'(0); center_y = FPW'(0);
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("por");

        push_frame(0, CX_A, CY_A);   // F0
        push_frame(3, CX_B, CY_B);   // F1: three edges during F0
        push_frame(3, CX_B, CY_B);   // F2: edge during LOAD not yet applied
        push_frame(4, CX_B, CY_B);   // F3: edge retained from LOAD
        push_frame(15, CX_B, CY_B);  // F4: saturated
        push_frame(14, CX_B, CY_B);  // F5: one zoom_out

        RESET = 1'b0;
        @(posedge CLK); #1;
        check("first_valid_idle", out_valid, 0);
        @(posedge CLK); #1;
        check("first_valid_load", out_valid, 1);
        check("first_valid_addr", addr, 0);

        // F0: stall at addr 2, then move the centre and zoom in mid-frame.
        wait_job(2);
        out_ready = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        out_ready = 1'b1;
        center_x = FPW'(100000); center_y = FPW'(-200000);
        repeat (3) pulse(1'b1, 1'b0);
        wait_frame_done();

        // F1 end: zoom_in edge lands in the LOAD cycle.
        wait_frame_done();
        zoom_in = 1'b1;
        @(posedge CLK); #1;
        zoom_in = 1'b0;
        wait_frame_done();

        // F3: hold the scan while saturating, then a simultaneous edge.
        wait_job(5);
        out_ready = 1'b0;
        repeat (20) pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        out_ready = 1'b1;
        wait_frame_done();

        // F4: one zoom_out edge.
        wait_job(5);
        out_ready = 1'b0;
        pulse(1'b0, 1'b1);
        out_ready = 1'b1;
        wait_frame_done();

        // F5: reset mid-frame at addr 7.
        wait_job(7);
        RESET = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        sb.delete();
        repeat (2) @(posedge CLK);
        #1;
        push_frame(0, CX_B, CY_B);   // F6
        RESET = 1'b0;
        @(posedge CLK); #1;
        check("restart_idle", out_valid, 0);
        @(posedge CLK); #1;
        check("restart_valid", out_valid, 1);
        check("restart_addr", addr, 0);
        wait_frame_done();
        check("queue_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
